// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serialises N requester ports onto one single-port
// synchronous RAM with registered read data (one-cycle read latency).
module ram_port_arbiter #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ARB_MODE   = 0,
    parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                             ram_clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             ack,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             busy,
    output logic [ID_WIDTH-1:0]              grant_id,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    // IDLE -> grant; WAIT -> RAM samples command; CAPTURE -> ack; DONE -> gap
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];

    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   ptr_n;
    logic [ID_WIDTH-1:0]   sel;
    logic [ID_WIDTH-1:0]   winner;
    logic                  found;

    logic                  op_we;
    logic                  op_we_n;
    logic                  mem_we_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic [DATA_WIDTH-1:0] mem_wdata_n;
    logic [DATA_WIDTH-1:0] rdata_n;
    logic [ID_WIDTH-1:0]   grant_id_n;
    logic [NUM_PORTS-1:0]  ack_n;

    genvar gp;
    generate
        for (gp = 0; gp < NUM_PORTS; gp++) begin : g_unpack
            assign addr_a[gp]  = req_addr[gp*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_a[gp] = req_wdata[gp*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign busy = (state != IDLE);

    // Winner search: scan from the far end so the first candidate wins last
    always_comb begin
        sel    = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (ARB_MODE == 1) begin
                sel = ID_WIDTH'((int'(ptr) + i) % NUM_PORTS);
            end else begin
                sel = ID_WIDTH'(i);
            end
            if (req[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
    end

    // Next state and next values of all registered outputs
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        op_we_n     = op_we;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        rdata_n     = rdata;
        grant_id_n  = grant_id;
        ack_n       = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n     = WAIT;
                    grant_id_n  = winner;
                    mem_addr_n  = addr_a[winner];
                    mem_wdata_n = wdata_a[winner];
                    mem_we_n    = req_we[winner];
                    op_we_n     = req_we[winner];
                    if (winner == ID_WIDTH'(NUM_PORTS - 1)) begin
                        ptr_n = '0;
                    end else begin
                        ptr_n = winner + 1'b1;
                    end
                end
            end
            WAIT: begin
                state_n = CAPTURE;
            end
            CAPTURE: begin
                if (!op_we) begin
                    rdata_n = mem_rdata;
                end
                ack_n[grant_id] = 1'b1;
                state_n         = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            op_we     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            grant_id  <= '0;
            ack       <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            op_we     <= op_we_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            rdata     <= rdata_n;
            grant_id  <= grant_id_n;
            ack       <= ack_n;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a fixed-priority and a round-robin instance
// share stimulus; each drives its own RAM and is checked every cycle.
module tb_ram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            ram_clr;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;

    logic [N-1:0]  ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          busy0, busy1;
    logic [IW-1:0] gid0, gid1;
    logic          we0, we1;
    logic [AW-1:0] ma0, ma1;
    logic [DW-1:0] mw0, mw1;
    logic [DW-1:0] mr0, mr1;

    ram_port_arbiter #(
        .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0)
    ) u0 (
        .ram_clk(clk), .rst(rst), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack0),
        .rdata(rdata0), .busy(busy0), .grant_id(gid0), .mem_we(we0),
        .mem_addr(ma0), .mem_wdata(mw0), .mem_rdata(mr0)
    );

    ram_port_arbiter #(
        .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1)
    ) u1 (
        .ram_clk(clk), .rst(rst), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack1),
        .rdata(rdata1), .busy(busy1), .grant_id(gid1), .mem_we(we1),
        .mem_addr(ma1), .mem_wdata(mw1), .mem_rdata(mr1)
    );

    logic [DW-1:0] ram0 [0:65535];
    logic [DW-1:0] ram1 [0:65535];

    // Single-port synchronous RAMs with registered read data
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 65536; i++) begin
                ram0[i] <= '0;
                ram1[i] <= '0;
            end
            ram0[16'h0010] <= 8'hA5;
            ram1[16'h0010] <= 8'hA5;
        end else begin
            if (we0) ram0[ma0] <= mw0;
            if (we1) ram1[ma1] <= mw1;
        end
        mr0 <= ram0[ma0];
        mr1 <= ram1[ma1];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: transaction-level view keyed on the grant edge
    int            kedge;
    int            g_edge [2];
    int            ptr    [2];
    int            g_port [2];
    bit            g_we   [2];
    logic [AW-1:0] g_addr [2];
    logic [DW-1:0] g_wd   [2];
    logic [DW-1:0] rv     [2];
    logic [DW-1:0] mm     [2][65536];

    logic [N-1:0]  e_ack   [2];
    logic [DW-1:0] e_rdata [2];
    logic          e_busy  [2];
    logic [IW-1:0] e_gid   [2];
    logic          e_we    [2];
    logic [AW-1:0] e_addr  [2];
    logic [DW-1:0] e_wd    [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            g_edge[m]  = -100;
            ptr[m]     = 0;
            e_ack[m]   = '0;
            e_rdata[m] = '0;
            e_busy[m]  = 1'b0;
            e_gid[m]   = '0;
            e_we[m]    = 1'b0;
            e_addr[m]  = '0;
            e_wd[m]    = '0;
        end
    endtask

    task automatic model_edge();
        int d;
        int p;
        kedge++;
        if (rst) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                d = kedge - g_edge[m];
                if (d == 1) begin
                    if (g_we[m]) mm[m][g_addr[m]] = g_wd[m];
                    else         rv[m] = mm[m][g_addr[m]];
                end
                if (d >= 4 && req != '0) begin
                    p = -1;
                    for (int i = 0; i < N; i++) begin
                        int q;
                        q = (m == 0) ? i : (ptr[m] + i) % N;
                        if (p < 0 && req[IW'(q)]) p = q;
                    end
                    g_edge[m] = kedge;
                    g_port[m] = p;
                    g_we[m]   = req_we[IW'(p)];
                    g_addr[m] = req_addr[p*AW +: AW];
                    g_wd[m]   = req_wdata[p*DW +: DW];
                    ptr[m]    = (p + 1) % N;
                    e_addr[m] = g_addr[m];
                    e_wd[m]   = g_wd[m];
                    e_gid[m]  = IW'(p);
                end
                d = kedge - g_edge[m];
                e_busy[m] = (d >= 0 && d <= 2);
                e_we[m]   = (d == 0) && g_we[m];
                e_ack[m]  = (d == 2) ? N'(1 << g_port[m]) : '0;
                if (d == 2 && !g_we[m]) e_rdata[m] = rv[m];
            end
        end
    endtask

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (edge %0d)",
                     nm, act, exp, kedge);
        end
    endtask

    task automatic check_outs();
        cmp("u0 ack",   32'(ack0),   32'(e_ack[0]));
        cmp("u0 rdata", 32'(rdata0), 32'(e_rdata[0]));
        cmp("u0 busy",  32'(busy0),  32'(e_busy[0]));
        cmp("u0 gid",   32'(gid0),   32'(e_gid[0]));
        cmp("u0 we",    32'(we0),    32'(e_we[0]));
        cmp("u0 addr",  32'(ma0),    32'(e_addr[0]));
        cmp("u0 wdata", 32'(mw0),    32'(e_wd[0]));
        cmp("u1 ack",   32'(ack1),   32'(e_ack[1]));
        cmp("u1 rdata", 32'(rdata1), 32'(e_rdata[1]));
        cmp("u1 busy",  32'(busy1),  32'(e_busy[1]));
        cmp("u1 gid",   32'(gid1),   32'(e_gid[1]));
        cmp("u1 we",    32'(we1),    32'(e_we[1]));
        cmp("u1 addr",  32'(ma1),    32'(e_addr[1]));
        cmp("u1 wdata", 32'(mw1),    32'(e_wd[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic set_port(input int p, input bit we,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req[IW'(p)]           = 1'b1;
        req_we[IW'(p)]        = we;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = wd;
    endtask

    // One isolated transaction: request for E0 only, ack checked at E2
    task automatic txn(input int p, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [N-1:0] x_ack,
                       input logic [DW-1:0] x_rd);
        req = '0;
        set_port(p, we, a, wd);
        step();
        cmp("txn addr", 32'(ma0), 32'(a));
        req = '0;
        step();
        step();
        cmp("txn ack u0",   32'(ack0),   32'(x_ack));
        cmp("txn rdata u0", 32'(rdata0), 32'(x_rd));
        cmp("txn ack u1",   32'(ack1),   32'(x_ack));
        cmp("txn rdata u1", 32'(rdata1), 32'(x_rd));
        step();
        step();
    endtask

    typedef struct {
        int            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [N-1:0]  x_ack;
        logic [DW-1:0] x_rd;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int fp_cyc  [3];
        int fp_port [3];
        int nfp;
        int seq [$];
        int cnt [3];
        int nack0, nack1, nbusy;
        logic [DW-1:0] ed_rd;

        tbl[0] = '{1, 1'b0, 16'h0010, 8'h00, 3'b010, 8'hA5};
        tbl[1] = '{2, 1'b1, 16'h0100, 8'h5C, 3'b100, 8'hA5};
        tbl[2] = '{0, 1'b0, 16'h0100, 8'h00, 3'b001, 8'h5C};
        tbl[3] = '{1, 1'b1, 16'hFFFF, 8'h3E, 3'b010, 8'h5C};
        tbl[4] = '{2, 1'b0, 16'hFFFF, 8'h00, 3'b100, 8'h3E};
        tbl[5] = '{0, 1'b0, 16'h0000, 8'h00, 3'b001, 8'h00};

        rst       = 1'b1;
        ram_clr   = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        kedge     = 0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 65536; i++) mm[m][i] = '0;
            mm[m][16'h0010] = 8'hA5;
            rv[m] = '0;
            g_port[m] = 0;
            g_we[m] = 1'b0;
        end
        model_reset();

        step();
        ram_clr = 1'b0;
        step();
        rst = 1'b0;
        step();

        for (int t = 0; t < 6; t++) begin
            txn(tbl[t].port, tbl[t].we, tbl[t].addr, tbl[t].wdata,
                tbl[t].x_ack, tbl[t].x_rd);
        end

        // Fixed priority: all request, each drops after its own ack
        for (int i = 0; i < 3; i++) begin
            fp_cyc[i]  = -1;
            fp_port[i] = -1;
        end
        nfp = 0;
        req = '0;
        for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(16'h0020 + p), '0);
        for (int c = 0; c < 14; c++) begin
            step();
            if (ack0 != '0) begin
                if (nfp < 3) begin
                    fp_cyc[nfp] = c;
                    for (int b = 0; b < N; b++) if (ack0[b]) fp_port[nfp] = b;
                end
                nfp++;
                req = req & ~ack0;
            end
        end
        req = '0;
        cmp("fp ack count", 32'(nfp), 32'd3);
        for (int i = 0; i < 3; i++) begin
            cmp("fp ack cycle", 32'(fp_cyc[i]), 32'(2 + 4 * i));
            cmp("fp ack port",  32'(fp_port[i]), 32'(i));
        end
        step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Round robin with every port requesting continuously
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        req = '0;
        for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(16'h0030 + p), '0);
        for (int c = 0; c < 48; c++) begin
            step();
            if (ack1 != '0) begin
                seq.push_back(int'(gid1));
                for (int b = 0; b < N; b++) if (ack1[b]) cnt[b]++;
            end
        end
        req = '0;
        cmp("rr ack count", 32'(seq.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            cmp("rr grant seq", (i < seq.size()) ? 32'(seq[i]) : 32'hFFFF_FFFF,
                32'(i % 3));
        end
        for (int i = 0; i < 3; i++) cmp("rr per-port", 32'(cnt[i]), 32'd4);
        for (int c = 0; c < 4; c++) step();

        // Asynchronous reset while a write sits in WAIT
        req = '0;
        set_port(2, 1'b1, 16'h0200, 8'h77);
        step();
        req = '0;
        #2;
        rst = 1'b1;
        #1;
        cmp("arst we u0",   32'(we0),   32'd0);
        cmp("arst busy u0", 32'(busy0), 32'd0);
        cmp("arst addr u0", 32'(ma0),   32'd0);
        cmp("arst we u1",   32'(we1),   32'd0);
        cmp("arst busy u1", 32'(busy1), 32'd0);
        model_reset();
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) step();
        cmp("arst ram0 kept", 32'(ram0[16'h0200]), 32'd0);
        cmp("arst ram1 kept", 32'(ram1[16'h0200]), 32'd0);
        txn(2, 1'b0, 16'h0200, 8'h00, 3'b100, 8'h00);

        // Early drop: one-cycle request still completes exactly once
        nack0 = 0;
        nack1 = 0;
        nbusy = 0;
        ed_rd = '0;
        req = '0;
        set_port(0, 1'b0, 16'h0010, 8'h00);
        step();
        req = '0;
        if (busy0) nbusy++;
        for (int c = 0; c < 8; c++) begin
            step();
            if (ack0[0]) begin
                nack0++;
                ed_rd = rdata0;
            end
            if (ack1[0]) nack1++;
            if (busy0) nbusy++;
        end
        cmp("drop acks u0",  32'(nack0), 32'd1);
        cmp("drop acks u1",  32'(nack1), 32'd1);
        cmp("drop rdata",    32'(ed_rd), 32'hA5);
        cmp("drop busy len", 32'(nbusy), 32'd3);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            req    = N'($urandom_range(0, 7));
            req_we = N'($urandom);
            for (int p = 0; p < N; p++) begin
                req_addr[p*AW +: AW]  = AW'($urandom_range(0, 63));
                req_wdata[p*DW +: DW] = DW'($urandom);
            end
            step();
        end
        req = '0;
        for (int c = 0; c < 6; c++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Parametrised N-port arbiter that serialises read/write requests from pipeline stages onto one single-port synchronous RAM (registered read data, one-cycle latency).
- Successor of the fixed three-port (fetch/read/save) RAM front end.
- Adds configurable port count and widths, selectable fixed-priority or round-robin arbitration, and fully clocked, registered operation.
- Sits between the stage modules and the ram instance inside cpu.

Parameters:
NUM_PORTS, 3, number of requester ports (>=2)
ADDR_WIDTH, 16, RAM address width
DATA_WIDTH, 8, RAM data width
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin
ID_WIDTH, $clog2(NUM_PORTS), width of grant_id

Ports:
ram_clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active high
req  in  NUM_PORTS  per-port request level
req_we  in  NUM_PORTS  per-port write enable (1 = write, 0 = read)
req_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data, same packing
ack  out  NUM_PORTS  one-cycle completion pulse per port
rdata  out  DATA_WIDTH  shared read data, valid while the matching ack is high
busy  out  1  high whenever state != IDLE
grant_id  out  ID_WIDTH  index of the port currently or last served
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM address
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM registered read data

Behaviour:
Reset:
- rst high forces immediately, without a clock: state IDLE; ack, mem_we, busy, grant_id, mem_addr, mem_wdata, rdata all 0; round-robin pointer 0.
- A transaction in flight at reset is dropped; no ack is issued for it.

FSM states:
- IDLE: on an edge with any req bit set, select winner p; latch mem_addr/mem_wdata/mem_we from port p; grant_id<=p; go to WAIT. With no request, stay in IDLE and hold mem_we=0.
- WAIT: RAM samples the command on this edge; mem_we<=0; go to CAPTURE.
- CAPTURE: on a read, rdata<=mem_rdata; on a write, rdata is unchanged. ack[p]<=1; go to DONE.
- DONE: ack<=0; go to IDLE. Requests are not evaluated in DONE.

Timing and handshake:
- Winner selected at edge E0; ack[p] is high from E2 to E3; next grant no earlier than E4. Throughput is one transaction per 4 cycles.
- Payload is sampled only at grant. A requester may drop req or change its payload after E0 without affecting the transaction; ack still pulses.
- A requester must deassert req, or present a new payload, by E4. If req is still high at E4, the port is served again (back-to-back); there is no double ack without a second grant.
- At most one ack bit is high at any time.

Arbitration:
- Mode 0: lowest set index of req wins.
- Mode 1: search starts at the pointer and wraps from NUM_PORTS-1 to 0. After granting port p, pointer<=(p+1) mod NUM_PORTS. The pointer is unchanged when there is no grant.
- Simultaneous requests: exactly one winner per grant edge; losers keep req high and wait, with no loss.

Widths:
- Addresses pass through unmodified; no wrap or range check inside the block.
- grant_id holds its value after DONE until the next grant.

Test Plan:
- Read: mem[0x0010]=0xA5, port 1 req read 0x0010 at E0 -> mem_addr=0x0010 at E0+, ack=3'b010 for one cycle at E2 with rdata=0xA5, busy high E0..E3.
- Write then read: port 2 writes 0x5C to 0x0100 (mem_we high exactly one cycle), then port 0 reads 0x0100 -> rdata=0x5C on ack[0]; rdata unchanged during the write ack.
- Fixed priority: ARB_MODE=0, req=3'b111 held, each port drops req after its ack -> service order 0,1,2; acks at cycles 2, 6, 10.
- Round robin: ARB_MODE=1, req=3'b111 held continuously for 12 grants -> grant_id sequence 0,1,2,0,1,2...; each port gets 4 acks.
- Reset mid-operation: assert rst asynchronously while in WAIT during a write -> mem_we drops immediately; no ack ever pulses for that request; after release, a fresh req is served normally from IDLE.
- Early drop: port 0 req pulses for one cycle only (E0) -> ack[0] still pulses at E2 with correct data; no second grant occurs.
